// File: rtl/clk_sel_ctrl_pkg.sv
// Shared definitions for the clock select controller.
// State encoding and select-line constants.
package clk_sel_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic SEL_CLK1 = 1'b1;
  localparam logic SEL_CLK2 = 1'b0;

endpackage

// File: rtl/clk_sel_ctrl_sync_2ff.sv
// Two-flop synchronizer for an asynchronous level.
// Clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_sel_ctrl.sv
// Owns the select line of the glitch-free clock switcher:
// request handshake, health checks, auto fallback, settle window.
module clk_sel_ctrl #(
  parameter int   SETTLE_W = 8,
  parameter logic DEF_SEL  = 1'b1,
  parameter bit   AUTO_FB  = 1'b1,
  parameter int   CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  input  logic                req_sel,
  output logic                req_rdy,
  input  logic [SETTLE_W-1:0] settle_cyc,
  input  logic                clk1_ok,
  input  logic                clk2_ok,
  output logic                sel_clk1,
  output logic                busy,
  output logic                done,
  output logic                req_err,
  output logic                fb_evt,
  output logic [CNT_W-1:0]    sw_cnt
);

  import clk_sel_ctrl_pkg::*;

  state_t              state;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] s_load;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                ok1_s;
  logic                ok2_s;
  logic                act_ok;
  logic                oth_ok;
  logic                tgt_ok;
  logic                fb_cond;
  logic                acc;

  sync_2ff u_sync1 (
    .clk (clk),
    .rst (rst),
    .d   (clk1_ok),
    .q   (ok1_s)
  );

  sync_2ff u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (clk2_ok),
    .q   (ok2_s)
  );

  assign act_ok  = (sel_clk1 == SEL_CLK1) ? ok1_s : ok2_s;
  assign oth_ok  = (sel_clk1 == SEL_CLK1) ? ok2_s : ok1_s;
  assign tgt_ok  = (req_sel == SEL_CLK1) ? ok1_s : ok2_s;
  assign fb_cond = AUTO_FB && (state == IDLE) && !act_ok && oth_ok;
  assign req_rdy = (state == IDLE) && !fb_cond;
  assign acc     = req_vld && req_rdy;
  assign busy    = (state == SETTLE);

  // A zero window still gives the switcher one full cycle
  assign s_load  = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;
  assign cnt_nxt = (sw_cnt == '1) ? sw_cnt : sw_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_clk1 <= DEF_SEL;
      done     <= 1'b0;
      req_err  <= 1'b0;
      fb_evt   <= 1'b0;
      sw_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      fb_evt  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fb_cond) begin
            sel_clk1 <= !sel_clk1;
            sw_cnt   <= cnt_nxt;
            fb_evt   <= 1'b1;
            cnt      <= s_load;
            state    <= SETTLE;
          end else if (acc) begin
            if (req_sel == sel_clk1) begin
              done <= 1'b1;
            end else if (!tgt_ok) begin
              req_err <= 1'b1;
            end else begin
              sel_clk1 <= req_sel;
              sw_cnt   <= cnt_nxt;
              cnt      <= s_load;
              state    <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt <= SETTLE_W'(1)) begin
            cnt   <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - SETTLE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
